// File: rtl/i2s_capture_pkg.sv
// Shared constants, slot positions and write-sequencer state encoding for the I2S capture path.
package i2s_capture_pkg;

  localparam int unsigned CHANNELS    = 8;
  localparam int unsigned CHAN_W      = 3;
  localparam int unsigned FRAME_W     = 6;
  localparam int unsigned BITS        = 16;
  localparam int unsigned POSN_W      = 6;
  localparam int unsigned LEFT_FIRST  = 1;
  localparam int unsigned RIGHT_FIRST = 33;

  typedef enum logic {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } state_e;

  // True when a bit position falls inside the BITS-wide capture window starting at first.
  function automatic logic in_slot(input logic [POSN_W-1:0] posn, input int unsigned first);
    return (32'(posn) >= first) && (32'(posn) < first + BITS);
  endfunction

endpackage

// File: rtl/i2s_rx_line.sv
// One I2S data line: sck-edge-gated left/right shift registers and the per-frame holding latch.
module i2s_rx_line
  import i2s_capture_pkg::*;
(
  input  logic              ck_i,
  input  logic              rst_ni,
  input  logic              rise_i,
  input  logic [POSN_W-1:0] frame_posn_i,
  input  logic              sd_i,
  input  logic              latch_i,
  output logic [BITS-1:0]   left_o,
  output logic [BITS-1:0]   right_o
);

  logic [BITS-1:0] left_sr_d, left_sr_q, right_sr_d, right_sr_q;
  logic [BITS-1:0] left_hl_d, left_hl_q, right_hl_d, right_hl_q;

  always_comb begin
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    left_hl_d  = left_hl_q;
    right_hl_d = right_hl_q;
    if (rise_i && in_slot(frame_posn_i, LEFT_FIRST)) begin
      left_sr_d = {left_sr_q[BITS-2:0], sd_i};
    end
    if (rise_i && in_slot(frame_posn_i, RIGHT_FIRST)) begin
      right_sr_d = {right_sr_q[BITS-2:0], sd_i};
    end
    if (latch_i) begin
      left_hl_d  = left_sr_q;
      right_hl_d = right_sr_q;
    end
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      left_sr_q  <= '0;
      right_sr_q <= '0;
      left_hl_q  <= '0;
      right_hl_q <= '0;
    end else begin
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
      left_hl_q  <= left_hl_d;
      right_hl_q <= right_hl_d;
    end
  end

  assign left_o  = left_hl_q;
  assign right_o = right_hl_q;

endmodule

// File: rtl/i2s_capture.sv
// Multi-line I2S receiver: rebuilds 8 x 16-bit channels per frame and writes them to the audio RAM.
// Optional test-pattern data source enabled by defining I2S_CAPTURE_TEST_PATTERN_EN.
module i2s_capture
  import i2s_capture_pkg::*;
#(
  parameter int unsigned Lines = 4
) (
  input  logic                      ck_i,
  input  logic                      rst_ni,
  input  logic                      sck_i,
  input  logic [POSN_W-1:0]         frame_posn_i,
  input  logic [Lines-1:0]          sd_i,
  input  logic                      hold_i,
  input  logic                      test_mode_i,
  output logic                      we_o,
  output logic [CHAN_W+FRAME_W-1:0] waddr_o,
  output logic [BITS-1:0]           wdata_o,
  output logic [FRAME_W-1:0]        frame_o,
  output logic                      frame_done_o,
  output logic                      skipped_o
);

  state_e                    state_d, state_q;
  logic [CHAN_W-1:0]         chan_d, chan_q;
  logic [FRAME_W-1:0]        frame_d, frame_q;
  logic                      last_d, last_q;
  logic                      we_d, we_q;
  logic [CHAN_W+FRAME_W-1:0] waddr_d, waddr_q;
  logic [BITS-1:0]           wdata_d, wdata_q;
  logic                      done_d, done_q;
  logic                      skipped_d, skipped_q;
  logic                      sck_q;
  logic                      rise, boundary, latch;
  logic [BITS-1:0]           chan_data [CHANNELS];

  assign rise     = sck_i & ~sck_q;
  assign boundary = rise && (frame_posn_i == '0);
  // A boundary arriving mid-sequence must not disturb the data still being written.
  assign latch    = boundary && (state_q == StIdle);

  for (genvar k = 0; k < int'(CHANNELS / 2); k++) begin : g_line
    if (k < int'(Lines)) begin : g_rx
      i2s_rx_line u_rx (
        .ck_i         (ck_i),
        .rst_ni       (rst_ni),
        .rise_i       (rise),
        .frame_posn_i (frame_posn_i),
        .sd_i         (sd_i[k]),
        .latch_i      (latch),
        .left_o       (chan_data[2*k]),
        .right_o      (chan_data[2*k+1])
      );
    end else begin : g_tie
      assign chan_data[2*k]   = '0;
      assign chan_data[2*k+1] = '0;
    end
  end

`ifdef I2S_CAPTURE_TEST_PATTERN_EN
  logic [BITS-1:0] src_data;
  assign src_data = test_mode_i ? {chan_q, 7'b0, 6'(frame_q)} : chan_data[chan_q];
`else
  logic [BITS-1:0] src_data;
  logic            unused_test_mode;
  assign src_data         = chan_data[chan_q];
  assign unused_test_mode = test_mode_i;
`endif

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    frame_d   = frame_q;
    last_d    = 1'b0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    skipped_d = boundary && (hold_i || (state_q == StWrite));
    // Completion is signalled one cycle after the chan 7 write leaves the sequencer.
    if (last_q && !hold_i) begin
      done_d  = 1'b1;
      frame_d = frame_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (boundary && !hold_i) begin
          state_d = StWrite;
          chan_d  = '0;
        end
      end
      StWrite: begin
        if (hold_i) begin
          state_d = StIdle;
        end else begin
          we_d    = 1'b1;
          waddr_d = {chan_q, frame_q};
          wdata_d = src_data;
          chan_d  = chan_q + 1'b1;
          if (chan_q == CHAN_W'(CHANNELS - 1)) begin
            state_d = StIdle;
            last_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q     <= 1'b0;
      state_q   <= StIdle;
      chan_q    <= '0;
      frame_q   <= '0;
      last_q    <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      sck_q     <= sck_i;
      state_q   <= state_d;
      chan_q    <= chan_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      skipped_q <= skipped_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign frame_o      = frame_q;
  assign frame_done_o = done_q;
  assign skipped_o    = skipped_q;

endmodule

// File: doc/i2s_capture.md
Name: i2s_capture

Overview:
- Multi-line I2S receiver and deserialiser; the capture end of the audio path.
- Samples up to 4 stereo I2S data lines, driven by the same sck/frame_posn generator as the I2S output, and rebuilds 8 channels of 16-bit audio per frame.
- Writes each completed frame into the audio-input dual-port RAM at {chan, frame}, then advances the frame index that the sequencer reads from.

Parameters:
- LINES, 4, number of I2S data input lines; CHANNELS = 2*LINES.
- FRAME_W, 6, frame index width; RAM holds 2^FRAME_W frames.
- BITS, 16, sample width captured per channel, MSB first.

Ports:
- ck  in  1  system clock; sck is a divided, ck-synchronous clock.
- rst  in  1  asynchronous active-low reset.
- sck  in  1  I2S bit clock from the i2s_clock generator.
- frame_posn  in  6  bit position 0..63 within the current I2S frame.
- sd  in  LINES  serial data; bit k is line k.
- hold  in  1  host owns the audio RAM (allow_audio_writes); suppresses RAM writes.
- test_mode  in  1  selects the test pattern (TEST_PATTERN_EN only).
- we  out  1  audio RAM write enable.
- waddr  out  3+FRAME_W  RAM write address {chan[2:0], frame[FRAME_W-1:0]}.
- wdata  out  16  RAM write data.
- frame  out  FRAME_W  frame index currently being filled.
- frame_done  out  1  one-cycle pulse after the 8th write of a frame.
- skipped  out  1  one-cycle pulse when a frame is dropped because of hold.

Behaviour:
- Reset (rst low, async): all outputs 0; shift registers, latches, frame and FSM cleared; state IDLE.
- Edge detect: sck_d registered from sck; rise = sck & ~sck_d. All sampling happens on ck cycles where rise=1.
- Sampling at rise with frame_posn = f:
  - f in 1..16: shift sd[k] into left_sr[k] (MSB first).
  - f in 33..48: shift sd[k] into right_sr[k].
  - All other positions are ignored; bits beyond 16 are truncated.
- Frame boundary, rise with f == 0: copy every left_sr/right_sr into the holding latches (hl), then:
  - hold = 0: go IDLE -> WRITE on the next cycle.
  - hold = 1: no write sequence; skipped pulses one cycle later; frame is not advanced.
- Channel map: chan 2k = left of line k; chan 2k+1 = right of line k.
- WRITE state:
  - Runs 8 consecutive cycles, chan counter 0..7.
  - we = 1, waddr = {chan, frame}, wdata = hl[chan], all registered.
  - The cycle after chan 7: we = 0, frame_done = 1, frame <= frame + 1 (wraps 2^FRAME_W-1 -> 0), back to IDLE.
- Latency: first we is 2 ck cycles after the f==0 rise; frame_done is 10 cycles after it.
- hold rising during WRITE: abort at the next cycle. we = 0, no frame_done, frame not advanced, back to IDLE.
- f==0 rise during WRITE: cannot occur (a frame lasts ≥ 64·2 ck). If it does, hl is not updated, skipped pulses, and the current write sequence completes.
- Unused channels (LINES < 4): written as 16'h0000.

Optional Feature:
- Macro: I2S_CAPTURE_TEST_PATTERN_EN.
- Defined: when test_mode = 1, wdata = {chan[2:0], 7'b0, frame[5:0]} in place of captured data. Timing, we and frame behaviour are unchanged.
- Undefined: test_mode is ignored and wdata is always captured data.

Decomposition:
- Shared audio package holds: CHANNELS, FRAME_W, BITS, I2S slot positions (LEFT_FIRST=1, RIGHT_FIRST=33), FSM state encoding (IDLE, WRITE).
- One natural sub-module, i2s_rx_line: one line's edge-gated left/right shift registers and latch, instantiated LINES times.
- Write sequencer, frame counter and address mux stay in the top level.

Test Plan:
- Reset: rst low mid-WRITE -> we = 0, frame = 0, state IDLE immediately; no writes after release until the next f==0 rise.
- Capture: line 0 sends left 16'hA5C3, right 16'h1234; line 3 sends 16'h8001 / 16'h7FFE. Next frame -> writes at waddr {0,f}=A5C3, {1,f}=1234, {6,f}=8001, {7,f}=7FFE. we is high exactly 8 cycles, starting 2 cycles after the f==0 rise.
- Wrap: run 65 frames from reset -> frame goes 63 -> 0 and the 65th frame writes at frame 0; 64 frame_done pulses by frame 64.
- Hold: hold = 1 at a frame boundary -> no we, skipped pulses once, frame unchanged. Hold asserted at chan 3 of WRITE -> writes stop, no frame_done.
- Truncation: 32-bit slot with low bits 16'hFFFF and top bits 16'h0F0F -> stored 16'h0F0F.
- I2S_CAPTURE_TEST_PATTERN_EN defined, test_mode = 1, frame = 5, chan = 6 -> wdata = 16'hC005.
